// File: rtl/bg_pkg.sv
// Shared types and constants for the vertical-scrolling background renderer.
package bg_pkg;

    localparam int COLOR_W_DEF = 12;
    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int TIMER_W     = 25;

    typedef logic [COLOR_W_DEF-1:0] color_t;

    localparam color_t FLASH_ON_COLOR  = 12'h00F;
    localparam color_t FLASH_OFF_COLOR = 12'h000;

    // Palette contents after reset; entries past the table come up black.
    function automatic color_t default_color(input int idx);
        color_t c;
        case (idx)
            0:       c = 12'hF00;
            1:       c = 12'h000;
            2:       c = 12'hD80;
            3:       c = 12'hFD7;
            4:       c = 12'hFEB;
            5:       c = 12'hFA9;
            6:       c = 12'hFFF;
            7:       c = 12'h372;
            8:       c = 12'hFE9;
            9:       c = 12'h899;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bg_palette.sv
// Writable palette with boss-mode flash override on one entry and a registered colour output.
module bg_palette
    import bg_pkg::*;
#(
    parameter int PAL_BITS    = 4,
    parameter int PAL_ENTRIES = 10,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int FLASH_IDX   = 6,
    parameter int FLASH_BIT   = 24
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [PAL_BITS-1:0] waddr_i,
    input  logic [COLOR_W-1:0]  wdata_i,
    input  logic                boss_i,
    input  logic                blank_i,
    input  logic [PAL_BITS-1:0] idx_i,
    output logic [COLOR_W-1:0]  color_o
);

    logic [COLOR_W-1:0] pal_q [PAL_ENTRIES];
    logic [COLOR_W-1:0] color_d, color_q;
    logic [TIMER_W-1:0] timer_d, timer_q;
    logic               boss_q, boss_rise, flash_phase;

    always_comb begin
        boss_rise   = boss_i & ~boss_q;
        // The rise cycle itself already counts as timer 0, so the first flash phase is always the lit one.
        timer_d     = boss_rise ? '0 : timer_q + TIMER_W'(1);
        flash_phase = boss_rise ? 1'b0 : timer_q[FLASH_BIT];
        color_d     = '0;
        if (!blank_i && (int'(idx_i) < PAL_ENTRIES)) begin
            color_d = pal_q[idx_i];
            if (boss_i && (int'(idx_i) == FLASH_IDX)) begin
                color_d = flash_phase ? COLOR_W'(FLASH_OFF_COLOR) : COLOR_W'(FLASH_ON_COLOR);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                pal_q[i] <= COLOR_W'(default_color(i));
            end
            timer_q <= '0;
            boss_q  <= 1'b0;
            color_q <= '0;
        end else begin
            if (we_i && (int'(waddr_i) < PAL_ENTRIES)) begin
                pal_q[waddr_i] <= wdata_i;
            end
            timer_q <= timer_d;
            boss_q  <= boss_i;
            color_q <= color_d;
        end
    end

    assign color_o = color_q;

endmodule

// File: rtl/bg_scroller.sv
// Vertical-scrolling background: per-frame offset counter, row wrap, ROM address pipeline
// and the blank flag delay line feeding the palette.
module bg_scroller
    import bg_pkg::*;
#(
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF,
    parameter int PAL_BITS    = 4,
    parameter int PAL_ENTRIES = 10,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int SPEED_W     = 4,
    parameter int ROM_LAT     = 1,
    parameter int FLASH_IDX   = 6,
    parameter int FLASH_BIT   = 24,
    localparam int ADDR_W     = $clog2(H_RES * V_RES)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                frame_tick,
    input  logic                Pause,
    input  logic                Boss,
    input  logic [SPEED_W-1:0]  speed,
    input  logic                dir,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                pal_we,
    input  logic [PAL_BITS-1:0] pal_waddr,
    input  logic [COLOR_W-1:0]  pal_wdata,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PAL_BITS-1:0] rom_q,
    output logic [COLOR_W-1:0]  background
);

    localparam int OFS_W = $clog2(V_RES);
    localparam logic [OFS_W:0] V_RES_O = (OFS_W + 1)'(V_RES);
    localparam logic [10:0]    V_RES_Y = 11'(V_RES);
    localparam logic [9:0]     H_LIM   = 10'(H_RES);
    localparam logic [9:0]     V_LIM   = 10'(V_RES);

    logic [OFS_W-1:0]   offset_d, offset_q;
    logic [OFS_W:0]     ofs_sum, ofs_diff;
    logic [10:0]        y_sum;
    logic [OFS_W-1:0]   idx_y_d, idx_y_q;
    logic [9:0]         x_q;
    logic               blank_d, blank1_q, blank2_q;
    logic [ROM_LAT-1:0] blank_dl_q;
    logic [ADDR_W-1:0]  rom_addr_d, rom_addr_q;

    always_comb begin
        ofs_sum  = {1'b0, offset_q} + (OFS_W + 1)'(speed);
        ofs_diff = {1'b0, offset_q} - (OFS_W + 1)'(speed);
        offset_d = offset_q;
        if (frame_tick && !Pause) begin
            if (!dir) begin
                offset_d = (ofs_sum >= V_RES_O) ? OFS_W'(ofs_sum - V_RES_O) : OFS_W'(ofs_sum);
            end else begin
                offset_d = ofs_diff[OFS_W] ? OFS_W'(ofs_diff + V_RES_O) : OFS_W'(ofs_diff);
            end
        end
        y_sum      = {1'b0, DrawY} + 11'(offset_q);
        idx_y_d    = (y_sum >= V_RES_Y) ? OFS_W'(y_sum - V_RES_Y) : OFS_W'(y_sum);
        blank_d    = (DrawX >= H_LIM) || (DrawY >= V_LIM);
        rom_addr_d = ADDR_W'(idx_y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            offset_q   <= '0;
            idx_y_q    <= '0;
            x_q        <= '0;
            rom_addr_q <= '0;
            // Pipeline leaves reset blanked so nothing is drawn until real pixels reach the output.
            blank1_q   <= 1'b1;
            blank2_q   <= 1'b1;
            blank_dl_q <= '1;
        end else begin
            offset_q   <= offset_d;
            idx_y_q    <= idx_y_d;
            x_q        <= DrawX;
            blank1_q   <= blank_d;
            rom_addr_q <= blank1_q ? '0 : rom_addr_d;
            blank2_q   <= blank1_q;
            blank_dl_q <= ROM_LAT'({blank_dl_q, blank2_q});
        end
    end

    assign rom_addr = rom_addr_q;

    bg_palette #(
        .PAL_BITS   (PAL_BITS),
        .PAL_ENTRIES(PAL_ENTRIES),
        .COLOR_W    (COLOR_W),
        .FLASH_IDX  (FLASH_IDX),
        .FLASH_BIT  (FLASH_BIT)
    ) u_palette (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .we_i   (pal_we),
        .waddr_i(pal_waddr),
        .wdata_i(pal_wdata),
        .boss_i (Boss),
        .blank_i(blank_dl_q[ROM_LAT-1]),
        .idx_i  (rom_q),
        .color_o(background)
    );

endmodule

// File: tb/tb_bg_scroller.sv
// Randomized bench for bg_scroller against a frame/pixel-level reference model.
module tb_bg_scroller;

    localparam int H   = 640;
    localparam int V   = 480;
    localparam int LAT = 1;
    localparam int FB  = 5;
    localparam int DEF_PAL [10] = '{'hF00, 'h000, 'hD80, 'hFD7, 'hFEB, 'hFA9, 'hFFF, 'h372, 'hFE9, 'h899};

    logic        CLK = 1'b0;
    logic        RESET, frame_tick, Pause, Boss, dir, pal_we;
    logic [3:0]  speed, pal_waddr, rom_q;
    logic [9:0]  DrawX, DrawY;
    logic [11:0] pal_wdata, background;
    logic [18:0] rom_addr;

    always #5 CLK = ~CLK;

    bg_scroller #(.ROM_LAT(LAT), .FLASH_BIT(FB)) dut (
        .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .Pause(Pause), .Boss(Boss),
        .speed(speed), .dir(dir), .DrawX(DrawX), .DrawY(DrawY), .pal_we(pal_we),
        .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .rom_addr(rom_addr), .rom_q(rom_q),
        .background(background)
    );

    int rom_force = -1;

    function automatic logic [3:0] rom_fn(input int a);
        return 4'((a ^ (a >> 4) ^ (a >> 9)) & 15);
    endfunction

    always @(posedge CLK) rom_q <= (rom_force >= 0) ? 4'(rom_force) : rom_fn(int'(rom_addr));

    typedef struct { bit valid; bit blank; int addr; int idx; } pix_t;
    pix_t pq[$];
    int   m_off;
    int   m_pal [16];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pix_t z;
        z = '{valid: 1'b0, blank: 1'b1, addr: 0, idx: 0};
        m_off = 0;
        for (int i = 0; i < 16; i++) m_pal[i] = (i < 10) ? DEF_PAL[i] : 0;
        pq.delete();
        repeat (3) pq.push_back(z);
    endtask

    // One pixel clock: register the pixel in the model, predict the output, advance, compare.
    task automatic cycle();
        pix_t p, q, t;
        int   exp_bg;
        bit   do_bg;
        p.valid = 1'b1;
        p.blank = (int'(DrawX) >= H) || (int'(DrawY) >= V);
        p.addr  = p.blank ? 0 : ((int'(DrawY) + m_off) % V) * H + int'(DrawX);
        p.idx   = 0;
        pq.push_back(p);
        q      = pq.pop_front();
        do_bg  = q.valid;
        exp_bg = 0;
        if (q.blank || q.idx >= 10) exp_bg = 0;
        else if (Boss && q.idx == 6) do_bg = 1'b0;
        else exp_bg = m_pal[q.idx];
        t     = pq[0];
        t.idx = (rom_force >= 0) ? rom_force : int'(rom_fn(t.addr));
        pq[0] = t;
        if (pal_we && int'(pal_waddr) < 10) m_pal[pal_waddr] = int'(pal_wdata);
        if (frame_tick && !Pause) m_off = (m_off + (dir ? V - int'(speed) : int'(speed))) % V;
        @(posedge CLK);
        #1;
        if (do_bg) chk("bg", int'(background), exp_bg);
        if (pq[1].valid) chk("rom_addr", int'(rom_addr), pq[1].addr);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        chk("rst_bg", int'(background), 0);
        chk("rst_addr", int'(rom_addr), 0);
    endtask

    task automatic probe(input string tag, input int exp_off);
        frame_tick = 1'b0;
        DrawX = '0;
        DrawY = '0;
        cycle();
        cycle();
        chk(tag, int'(rom_addr), exp_off * H);
    endtask

    initial begin
        RESET = 1'b1; frame_tick = 0; Pause = 0; Boss = 0; dir = 0; speed = '0;
        DrawX = '0; DrawY = '0; pal_we = 0; pal_waddr = '0; pal_wdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        do_reset();

        // First pixel through the pipe.
        rom_force = 3; DrawX = 10'd5; DrawY = 10'd0;
        repeat (3 + LAT) cycle();
        chk("first_addr", int'(rom_addr), 5);
        chk("first_bg", int'(background), 'hFD7);

        // Offset wrap in both directions, pause and zero speed.
        rom_force = -1; speed = 4'd4; dir = 1'b0;
        frame_tick = 1'b1;
        repeat (119) cycle();
        probe("ofs_476", 476);
        frame_tick = 1'b1; cycle();
        probe("ofs_wrap", 0);
        dir = 1'b1; frame_tick = 1'b1; cycle();
        probe("ofs_borrow", 476);
        Pause = 1'b1; frame_tick = 1'b1; cycle();
        probe("ofs_pause", 476);
        Pause = 1'b0; speed = 4'd0; frame_tick = 1'b1; cycle();
        probe("ofs_speed0", 476);
        speed = 4'd4;

        // Blanking beats a valid ROM index.
        rom_force = 3; DrawX = 10'd640; DrawY = 10'd0;
        repeat (4) cycle();
        chk("blank_x", int'(background), 0);
        DrawX = 10'd0; DrawY = 10'd500;
        repeat (4) cycle();
        chk("blank_y", int'(background), 0);
        DrawX = 10'd639; DrawY = 10'd479;
        repeat (4) cycle();
        chk("last_px", int'(background), 'hFD7);

        // Palette writes: same-cycle read returns old value, out-of-range writes ignored.
        rom_force = 2; DrawX = 10'd1; DrawY = 10'd1;
        repeat (4) cycle();
        pal_we = 1'b1; pal_waddr = 4'd2; pal_wdata = 12'hABC;
        cycle();
        pal_we = 1'b0;
        chk("wr_old", int'(background), 'hD80);
        cycle();
        chk("wr_new", int'(background), 'hABC);
        pal_we = 1'b1; pal_waddr = 4'd12; pal_wdata = 12'h123;
        cycle();
        pal_we = 1'b0;
        for (int e = 0; e < 16; e++) begin
            rom_force = e;
            repeat (4) cycle();
            chk("pal_sweep", int'(background), (e < 10) ? m_pal[e] : 0);
        end

        // Randomized traffic with a reset in the middle.
        rom_force = -1;
        for (int i = 0; i < 3000; i++) begin
            DrawX      = 10'($urandom_range(0, 700));
            DrawY      = 10'($urandom_range(0, 520));
            frame_tick = ($urandom_range(0, 15) == 0);
            Pause      = ($urandom_range(0, 3) == 0);
            dir        = 1'($urandom);
            speed      = 4'($urandom);
            pal_we     = ($urandom_range(0, 7) == 0);
            pal_waddr  = 4'($urandom);
            pal_wdata  = 12'($urandom);
            if (i == 1500) begin
                do_reset();
                pal_we = 1'b0;
                probe("rst_ofs", 0);
            end else begin
                cycle();
            end
        end
        pal_we = 1'b0; frame_tick = 1'b0; Pause = 1'b0;

        // Boss flash: timer parked in the dark phase, Boss rise must restart lit.
        do_reset();
        rom_force = 6; DrawX = 10'd10; DrawY = 10'd10; Boss = 1'b0;
        repeat (40) cycle();
        Boss = 1'b1;
        cycle();
        chk("boss_start", int'(background), 'h00F);
        repeat (2) cycle();
        chk("boss_lit", int'(background), 'h00F);
        repeat (34) cycle();
        chk("boss_dark", int'(background), 'h000);
        Boss = 1'b0;
        cycle();
        chk("boss_off", int'(background), 'hFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
